// File: rtl/cap_board_decoder_seq.sv
// Cap-board decoder: debounces the board address switches, qualifies the tuning strobe and
// walks board_out one bit at a time toward a thermometer target. Optional macro: ADDR_LOCK_EN.
module cap_board_decoder_seq #(
    parameter int NUM_IDS    = 4,
    parameter int SW_WIDTH   = 6,
    parameter int CODE_WIDTH = 7,
    parameter int EN_WAIT    = 4,
    parameter int ADDR_WAIT  = 15,
    parameter int STEP_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   sw_in,
    input  logic                  enable,
    input  logic [CODE_WIDTH-1:0] tuning_code,
    output logic [NUM_IDS-1:0]    board_out,
    output logic                  busy,
    output logic                  addr_valid,
    output logic [CODE_WIDTH-1:0] base_addr
);

    localparam int LOG_N = $clog2(NUM_IDS);
    localparam int BW    = SW_WIDTH + LOG_N + 1;
    localparam int CMPW  = ((BW > CODE_WIDTH) ? BW : CODE_WIDTH) + 1;
    localparam int AW    = (ADDR_WAIT > 0) ? $clog2(ADDR_WAIT + 1) : 1;
    localparam int ENW   = $clog2(EN_WAIT + 1);
    localparam int GW    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, GAP} state_t;

    logic [SW_WIDTH-1:0] swPrev;
    logic [SW_WIDTH-1:0] swStable;
    logic [AW-1:0]       addrCnt;
    logic                acceptOk;
    logic [SW_WIDTH-1:0] board;
    logic [BW-1:0]       baseCalc;
    logic [BW-1:0]       baseReg;
    logic                addrValid;
    logic [ENW-1:0]      enCnt;
    logic                qualified;
    logic [NUM_IDS-1:0]  sampleTarget;

    state_t              state, stateNext;
    logic [NUM_IDS-1:0]  boardOut, boardNext;
    logic                busyReg, busyNext;
    logic [NUM_IDS-1:0]  target, targetNext;
    logic [GW-1:0]       gapCnt, gapNext;
    logic [NUM_IDS-1:0]  tgtEff, clrMask, setMask, stepMask, stepOut;

`ifdef ADDR_LOCK_EN
    // Only board 0 (all switches off) may be replaced; the first real board sticks until reset.
    assign acceptOk = (swStable == '1);
`else
    assign acceptOk = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            swPrev   <= '1;
            swStable <= '1;
            addrCnt  <= '0;
        end else if (sw_in != swPrev) begin
            swPrev  <= sw_in;
            addrCnt <= '0;
        end else if (addrCnt < AW'(ADDR_WAIT)) begin
            addrCnt <= addrCnt + AW'(1);
        end else if (acceptOk) begin
            swStable <= swPrev;
        end
    end

    assign board    = ~swStable;
    assign baseCalc = ((BW'(board) - BW'(1)) << LOG_N) + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            baseReg   <= '0;
            addrValid <= 1'b0;
        end else begin
            addrValid <= (board != '0);
            baseReg   <= (board != '0) ? baseCalc : '0;
        end
    end

    assign addr_valid = addrValid;
    assign base_addr  = CODE_WIDTH'(baseReg);

    always_ff @(posedge clk) begin
        if (rst || !enable || (enCnt == ENW'(EN_WAIT - 1))) begin
            enCnt <= '0;
        end else begin
            enCnt <= enCnt + ENW'(1);
        end
    end

    assign qualified = enable && (enCnt == ENW'(EN_WAIT - 1));

    // Compare at full width so bases beyond the tuning code range yield a zero target.
    always_comb begin
        sampleTarget = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            sampleTarget[i] = addrValid && (CMPW'(tuning_code) >= (CMPW'(baseReg) + CMPW'(i)));
        end
    end

    // Break-before-make: drop the highest surplus bit first, otherwise add the lowest missing one.
    always_comb begin
        tgtEff   = addrValid ? target : '0;
        clrMask  = boardOut & ~tgtEff;
        setMask  = ~boardOut & tgtEff;
        stepMask = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (clrMask[i]) stepMask = NUM_IDS'(1) << i;
        end
        if (clrMask == '0) stepMask = setMask & (~setMask + NUM_IDS'(1));
        stepOut = boardOut ^ stepMask;
    end

    always_comb begin
        stateNext  = state;
        boardNext  = boardOut;
        busyNext   = busyReg;
        targetNext = target;
        gapNext    = gapCnt;
        case (state)
            IDLE: begin
                if (qualified) begin
                    targetNext = sampleTarget;
                    if (sampleTarget != boardOut) begin
                        stateNext = APPLY;
                        busyNext  = 1'b1;
                    end
                end
            end
            APPLY: begin
                boardNext = stepOut;
                gapNext   = '0;
                if (stepOut != tgtEff) begin
                    stateNext = (STEP_GAP > 0) ? GAP : APPLY;
                end else begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end
            end
            GAP: begin
                if (gapCnt == GW'(STEP_GAP - 1)) begin
                    stateNext = APPLY;
                    gapNext   = '0;
                end else begin
                    gapNext = gapCnt + GW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            boardOut <= '0;
            busyReg  <= 1'b0;
            target   <= '0;
            gapCnt   <= '0;
        end else begin
            state    <= stateNext;
            boardOut <= boardNext;
            busyReg  <= busyNext;
            target   <= targetNext;
            gapCnt   <= gapNext;
        end
    end

    assign board_out = boardOut;
    assign busy      = busyReg;

endmodule

// File: tb/tb_cap_board_decoder_seq.sv
// Bench for cap_board_decoder_seq: directed scenarios plus randomized boards/codes checked
// against a step-sequence reference model.
module tb_cap_board_decoder_seq;

    localparam int NUM_IDS    = 4;
    localparam int SW_WIDTH   = 6;
    localparam int CODE_WIDTH = 7;
    localparam int EN_WAIT    = 4;
    localparam int ADDR_WAIT  = 15;
    localparam int STEP_GAP   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [SW_WIDTH-1:0]   sw_in;
    logic                  enable;
    logic [CODE_WIDTH-1:0] tuning_code;
    logic [NUM_IDS-1:0]    board_out;
    logic                  busy;
    logic                  addr_valid;
    logic [CODE_WIDTH-1:0] base_addr;

    int checks   = 0;
    int failures = 0;

    logic [NUM_IDS-1:0] modelOut;
    int                 modelBoard;
    logic [NUM_IDS-1:0] exp_q[$];

    cap_board_decoder_seq #(
        .NUM_IDS(NUM_IDS), .SW_WIDTH(SW_WIDTH), .CODE_WIDTH(CODE_WIDTH),
        .EN_WAIT(EN_WAIT), .ADDR_WAIT(ADDR_WAIT), .STEP_GAP(STEP_GAP)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .enable(enable), .tuning_code(tuning_code),
        .board_out(board_out), .busy(busy), .addr_valid(addr_valid), .base_addr(base_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int baseOf(input int b);
        return (b - 1) * NUM_IDS + 1;
    endfunction

    function automatic logic [NUM_IDS-1:0] targetOf(input int code, input int b);
        logic [NUM_IDS-1:0] t;
        t = '0;
        if (b != 0) begin
            for (int i = 0; i < NUM_IDS; i++) t[i] = (code >= baseOf(b) + i);
        end
        return t;
    endfunction

    function automatic logic [NUM_IDS-1:0] stepToward(input logic [NUM_IDS-1:0] cur,
                                                      input logic [NUM_IDS-1:0] tgt);
        logic [NUM_IDS-1:0] r;
        r = cur;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (cur[i] && !tgt[i]) begin
                r[i] = 1'b0;
                return r;
            end
        end
        for (int i = 0; i < NUM_IDS; i++) begin
            if (!cur[i] && tgt[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic acceptBoard(input int b);
`ifdef ADDR_LOCK_EN
        if (modelBoard == 0) modelBoard = b;
`else
        modelBoard = b;
`endif
    endtask

    task automatic checkAddr(input string tag);
        check({tag, "_addr_valid"}, addr_valid, modelBoard != 0);
        check({tag, "_base_addr"}, base_addr,
              (modelBoard != 0) ? (baseOf(modelBoard) & ((1 << CODE_WIDTH) - 1)) : 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        modelOut   = '0;
        modelBoard = 0;
        check("rst_board_out", board_out, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_base_addr", base_addr, 0);
    endtask

    task automatic setBoard(input int b);
        logic [31:0] bv;
        bv = b;
        @(negedge clk);
        sw_in = ~bv[SW_WIDTH-1:0];
        repeat (ADDR_WAIT + 3) @(negedge clk);
        acceptBoard(b);
        checkAddr("set_board");
    endtask

    task automatic sampleAndWalk(input int code, input string tag);
        logic [31:0]        cv;
        logic [NUM_IDS-1:0] tgt, cur, expB;
        int                 steps, lastEdge, total, k;
        cv = code;
        @(negedge clk);
        enable      = 1'b1;
        tuning_code = cv[CODE_WIDTH-1:0];
        repeat (EN_WAIT) @(negedge clk);
        enable = 1'b0;
        tgt = targetOf(code, modelBoard);
        exp_q.delete();
        cur = modelOut;
        while (cur != tgt && exp_q.size() < 2 * NUM_IDS) begin
            cur = stepToward(cur, tgt);
            exp_q.push_back(cur);
        end
        steps    = exp_q.size();
        lastEdge = 1 + (steps - 1) * (STEP_GAP + 1);
        total    = (steps == 0) ? 4 : lastEdge + 2;
        check({tag, "_busy_at_sample"}, busy, steps > 0);
        check({tag, "_out_at_sample"}, board_out, modelOut);
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            k = (steps == 0) ? 0 : ((n - 1) / (STEP_GAP + 1) + 1);
            if (k > steps) k = steps;
            expB = (k == 0) ? modelOut : exp_q[k-1];
            check({tag, "_board_out"}, board_out, expB);
            check({tag, "_busy"}, busy, (steps > 0) && (n < lastEdge));
        end
        modelOut = tgt;
    endtask

    task automatic enableGlitch(input int code, input string tag);
        logic [31:0] cv;
        cv = code;
        @(negedge clk);
        enable      = 1'b1;
        tuning_code = cv[CODE_WIDTH-1:0];
        repeat (EN_WAIT - 1) @(negedge clk);
        enable = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check({tag, "_board_out"}, board_out, modelOut);
            check({tag, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        #500000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int b, code;
        rst         = 1'b1;
        enable      = 1'b0;
        tuning_code = '0;
        sw_in       = 6'b111101;
        modelOut    = '0;
        modelBoard  = 0;

        // Acquisition from reset with board 2 (base 5).
        resetDut();
        repeat (ADDR_WAIT + 3) @(negedge clk);
        acceptBoard(2);
        checkAddr("acquire");

        sampleAndWalk(7, "walk_up");
        sampleAndWalk(5, "walk_down");
        sampleAndWalk(7, "walk_up2");
        enableGlitch(20, "glitch");

        // Switches to board 0 then resample: clears stepwise unless the address is locked.
        setBoard(0);
        sampleAndWalk(20, "board0_clear");

        // Board 0 from reset never drives outputs.
        sw_in = '1;
        resetDut();
        setBoard(0);
        sampleAndWalk(20, "board0_idle");

        // Reset during the gap after the first step.
        setBoard(2);
        @(negedge clk);
        enable      = 1'b1;
        tuning_code = 7'd7;
        repeat (EN_WAIT) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("midwalk_first_step", board_out, 4'b0001);
        check("midwalk_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midwalk_rst_board_out", board_out, 0);
        check("midwalk_rst_busy", busy, 0);
        rst        = 1'b0;
        modelOut   = '0;
        modelBoard = 0;
        setBoard(2);

        // Later switch change: tracked normally, ignored once locked.
        setBoard(3);
        sampleAndWalk(10, "after_change");

        // Base beyond the code range: truncated base_addr, zero target.
        setBoard(33);
        sampleAndWalk(127, "wide_base");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 63);
                setBoard(b);
            end
            if (modelBoard != 0 && $urandom_range(0, 1) == 0) begin
                code = baseOf(modelBoard) + $urandom_range(0, NUM_IDS + 2) - 2;
                if (code < 0) code = 0;
                if (code > 127) code = 127;
            end else begin
                code = $urandom_range(0, 127);
            end
            if ($urandom_range(0, 4) == 0) enableGlitch(code, "rnd_glitch");
            else sampleAndWalk(code, "rnd_walk");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
